// File: rtl/mm_seq_ctrl_if.sv
// Handshake bundle between the matrix-multiply sequencer and its RX/TX/multiplier neighbours.
// The address width is derived from the same sizing parameters as the controller.
interface mm_seq_ctrl_if #(
    parameter int DIM       = 2,
    parameter int IN_BYTES  = 1,
    parameter int OUT_BYTES = 2
);
    localparam int RX_COUNT  = 2 * DIM * DIM * IN_BYTES;
    localparam int TX_COUNT  = DIM * DIM * OUT_BYTES;
    localparam int MAX_COUNT = (RX_COUNT > TX_COUNT) ? RX_COUNT : TX_COUNT;
    localparam int AW        = ($clog2(MAX_COUNT) < 1) ? 1 : $clog2(MAX_COUNT);

    logic          rx_valid;
    logic          tx_busy;
    logic          mult_done;
    logic          abort;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          mult_start;
    logic [AW-1:0] rd_addr;
    logic          tx_start;
    logic          busy;
    logic          err;
    logic          overrun;
    logic [2:0]    state;

    modport master (
        input  rx_valid, tx_busy, mult_done, abort,
        output wr_en, wr_addr, mult_start, rd_addr, tx_start, busy, err, overrun, state
    );

    modport slave (
        output rx_valid, tx_busy, mult_done, abort,
        input  wr_en, wr_addr, mult_start, rd_addr, tx_start, busy, err, overrun, state
    );
endinterface

// File: rtl/mm_seq_ctrl.sv
// Sequencer: load operand bytes from RX, kick the multiplier with a timeout, stream results to TX.
// Writes are combinational on rx_valid; TX pacing follows tx_busy, one byte per start pulse.
module mm_seq_ctrl #(
    parameter int DIM       = 2,
    parameter int IN_BYTES  = 1,
    parameter int OUT_BYTES = 2,
    parameter int TIMEOUT   = 65535
) (
    input  logic          clk,
    input  logic          rst,
    mm_seq_ctrl_if.master bus
);
    localparam int RX_COUNT  = 2 * DIM * DIM * IN_BYTES;
    localparam int TX_COUNT  = DIM * DIM * OUT_BYTES;
    localparam int MAX_COUNT = (RX_COUNT > TX_COUNT) ? RX_COUNT : TX_COUNT;
    localparam int AW        = ($clog2(MAX_COUNT) < 1) ? 1 : $clog2(MAX_COUNT);
    localparam int TW        = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] RX_LAST = AW'(RX_COUNT - 1);
    localparam logic [AW-1:0] TX_LAST = AW'(TX_COUNT - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] START   = 3'd2;
    localparam logic [2:0] COMPUTE = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;
    localparam logic [2:0] TX_WAIT = 3'd5;
    localparam logic [2:0] ERROR   = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] rd_q;
    logic [TW-1:0] tcnt_q;
    logic          tw_entry_q;
    logic          err_q;
    logic          overrun_q;

    logic          wr_en_c;
    logic          mult_start_c;
    logic          tx_start_c;
    logic          busy_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.rx_valid) state_d = (RX_COUNT == 1) ? START : LOAD;
                LOAD:    if (bus.rx_valid && cnt_q == RX_LAST) state_d = START;
                START:   state_d = COMPUTE;
                COMPUTE: begin
                    // done takes precedence over a timeout landing on the same cycle
                    if (bus.mult_done)        state_d = SEND;
                    else if (tcnt_q == TO_LAST) state_d = ERROR;
                end
                SEND:    if (!bus.tx_busy) state_d = TX_WAIT;
                TX_WAIT: begin
                    if (!tw_entry_q && !bus.tx_busy) state_d = (rd_q == TX_LAST) ? IDLE : SEND;
                end
                ERROR:   state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en_c      = 1'b0;
        mult_start_c = 1'b0;
        tx_start_c   = 1'b0;
        busy_c       = 1'b0;
        if (!rst && !bus.abort) begin
            case (state_q)
                IDLE, LOAD: wr_en_c      = bus.rx_valid;
                START:      mult_start_c = 1'b1;
                SEND:       tx_start_c   = !bus.tx_busy;
                default:    ;
            endcase
        end
        case (state_q)
            LOAD, START, COMPUTE, SEND, TX_WAIT: busy_c = 1'b1;
            default:                             busy_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            rd_q       <= '0;
            tcnt_q     <= '0;
            tw_entry_q <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (bus.abort) begin
            cnt_q      <= '0;
            rd_q       <= '0;
            tcnt_q     <= '0;
            tw_entry_q <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // tx_busy only rises the cycle after tx_start, so the TX_WAIT entry cycle is skipped
            tw_entry_q <= tx_start_c;

            if (wr_en_c) begin
                cnt_q <= (state_d == START) ? '0 : cnt_q + 1'b1;
            end

            if (state_q == START) begin
                tcnt_q <= '0;
            end else if (state_q == COMPUTE && !bus.mult_done) begin
                tcnt_q <= tcnt_q + 1'b1;
            end

            if (state_q == COMPUTE && bus.mult_done) begin
                rd_q <= '0;
            end else if (state_q == TX_WAIT && state_d != TX_WAIT) begin
                rd_q <= (state_d == IDLE) ? '0 : rd_q + 1'b1;
            end

            if (state_q == COMPUTE && state_d == ERROR) begin
                err_q <= 1'b1;
            end

            if (bus.rx_valid && state_q != IDLE && state_q != LOAD) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.wr_en      = wr_en_c;
    assign bus.wr_addr    = cnt_q;
    assign bus.mult_start = mult_start_c;
    assign bus.rd_addr    = rd_q;
    assign bus.tx_start   = tx_start_c;
    assign bus.busy       = busy_c;
    assign bus.err        = err_q;
    assign bus.overrun    = overrun_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Bench for mm_seq_ctrl: per-cycle vector table plus scoreboarded job sequences on three sizings.
module tb_mm_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic rx_valid = 1'b0, mult_done = 1'b0, abort = 1'b0, force_busy = 1'b0;
    logic tx_busy;
    int   txlen = 2;
    int   bcnt;
    int   total = 0, bad = 0;
    int   sel = 0;
    bit   mon_en = 1'b0;
    int   wq[$];
    int   rq[$];
    int   ntx = 0, nms = 0, last_rd = 0;

    // u0: nominal sizing, u1: short timeout, u2: DIM=1
    mm_seq_ctrl_if #(.DIM(2), .IN_BYTES(1), .OUT_BYTES(2)) u_if0 ();
    mm_seq_ctrl_if #(.DIM(2), .IN_BYTES(1), .OUT_BYTES(2)) u_if1 ();
    mm_seq_ctrl_if #(.DIM(1), .IN_BYTES(1), .OUT_BYTES(2)) u_if2 ();

    mm_seq_ctrl #(.DIM(2), .IN_BYTES(1), .OUT_BYTES(2), .TIMEOUT(64)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0));
    mm_seq_ctrl #(.DIM(2), .IN_BYTES(1), .OUT_BYTES(2), .TIMEOUT(10)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));
    mm_seq_ctrl #(.DIM(1), .IN_BYTES(1), .OUT_BYTES(2), .TIMEOUT(64)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2));

    assign u_if0.rx_valid = rx_valid;  assign u_if1.rx_valid = rx_valid;  assign u_if2.rx_valid = rx_valid;
    assign u_if0.tx_busy  = tx_busy;   assign u_if1.tx_busy  = tx_busy;   assign u_if2.tx_busy  = tx_busy;
    assign u_if0.mult_done = mult_done; assign u_if1.mult_done = mult_done; assign u_if2.mult_done = mult_done;
    assign u_if0.abort    = abort;     assign u_if1.abort    = abort;     assign u_if2.abort    = abort;

    logic [2:0] o_state;
    logic [3:0] o_wa, o_rd;
    logic       o_we, o_ms, o_ts, o_bz, o_ov, o_er;

    always_comb begin
        case (sel)
            1: begin
                o_state = u_if1.state; o_we = u_if1.wr_en; o_wa = 4'(u_if1.wr_addr); o_rd = 4'(u_if1.rd_addr);
                o_ms = u_if1.mult_start; o_ts = u_if1.tx_start; o_bz = u_if1.busy; o_ov = u_if1.overrun; o_er = u_if1.err;
            end
            2: begin
                o_state = u_if2.state; o_we = u_if2.wr_en; o_wa = 4'(u_if2.wr_addr); o_rd = 4'(u_if2.rd_addr);
                o_ms = u_if2.mult_start; o_ts = u_if2.tx_start; o_bz = u_if2.busy; o_ov = u_if2.overrun; o_er = u_if2.err;
            end
            default: begin
                o_state = u_if0.state; o_we = u_if0.wr_en; o_wa = 4'(u_if0.wr_addr); o_rd = 4'(u_if0.rd_addr);
                o_ms = u_if0.mult_start; o_ts = u_if0.tx_start; o_bz = u_if0.busy; o_ov = u_if0.overrun; o_er = u_if0.err;
            end
        endcase
    end

    // UART TX model: busy rises the cycle after tx_start and lasts txlen cycles
    always @(posedge clk or posedge rst) begin
        if (rst)            bcnt <= 0;
        else if (o_ts)      bcnt <= txlen;
        else if (bcnt > 0)  bcnt <= bcnt - 1;
    end
    assign tx_busy = force_busy || (bcnt != 0);

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, req, $time);
        end
    endtask

    function automatic int outv();
        return int'({o_state, o_we, o_wa, o_ms, o_ts, o_bz, o_ov, o_er});
    endfunction

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (o_we) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected actual=%0d required=no_write", o_wa);
                end else begin
                    chk("wr_addr", int'(o_wa), wq.pop_front());
                end
            end
            if (o_ms) nms++;
            if (o_ts) begin
                ntx++;
                chk("tx_start_while_busy", int'(tx_busy), 0);
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected actual=%0d required=no_start", o_rd);
                end else begin
                    chk("rd_addr", int'(o_rd), rq.pop_front());
                end
                last_rd = int'(o_rd);
            end
            if (o_state == 3'd5) chk("rd_addr_stable", int'(o_rd), last_rd);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset(input int s);
        rst = 1'b1; rx_valid = 1'b0; mult_done = 1'b0; abort = 1'b0; force_busy = 1'b0;
        sel = s;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wq.delete(); rq.delete();
        ntx = 0; nms = 0; last_rd = 0;
    endtask

    task automatic send_byte(input int a);
        rx_valid = 1'b1;
        if (mon_en) wq.push_back(a);
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int n = 0;
        while (o_state != s && n < budget) begin
            cyc(); smp(); n++;
        end
        chk(nm, int'(o_state), int'(s));
    endtask

    task automatic fire_done(input int cnt);
        mult_done = 1'b1;
        for (int k = 0; k < cnt; k++) rq.push_back(k);
        cyc();
        mult_done = 1'b0;
    endtask

    typedef struct packed {
        logic       rx;
        logic       ab;
        logic [2:0] st;
        logic       we;
        logic [3:0] wa;
        logic       ms;
        logic       ts;
        logic       bz;
        logic       ov;
        logic       er;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int n;
        tbl[0] = '{1'b1, 1'b0, 3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i < 8; i++)
            tbl[i] = '{1'b1, 1'b0, 3'd1, 1'b1, 4'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 3'd2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 3'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 3'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 3'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 3'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 3'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset state, then back-to-back load / overrun / abort vectors
        do_reset(0);
        smp();
        chk("reset_outputs", outv(), 0);
        chk("reset_rd_addr", int'(o_rd), 0);
        cyc();
        for (int i = 0; i < 18; i++) begin
            rx_valid = tbl[i].rx;
            abort    = tbl[i].ab;
            smp();
            chk($sformatf("vec%0d", i), outv(), int'(tbl[i][12:0]));
            cyc();
        end
        rx_valid = 1'b0; abort = 1'b0;

        // nominal job: bytes 3 cycles apart, done after 20 cycles
        do_reset(0);
        mon_en = 1'b1; txlen = 2;
        for (int i = 0; i < 8; i++) begin
            send_byte(i);
            if (i < 7) repeat (2) cyc();
        end
        smp(); chk("mult_start_pulse", int'(o_ms), 1);
        cyc(); smp(); chk("mult_start_single", int'(o_ms), 0);
        chk("compute_entry", int'(o_state), 3);
        repeat (19) cyc();
        fire_done(8);
        wait_state(3'd0, 400, "nominal_idle");
        chk("nominal_tx_count", ntx, 8);
        chk("nominal_ms_count", nms, 1);
        chk("nominal_busy", int'(o_bz), 0);
        chk("nominal_rq_left", rq.size(), 0);
        chk("nominal_wq_left", wq.size(), 0);

        // tx_busy already high entering SEND, then slow UART
        do_reset(0);
        txlen = 5;
        for (int i = 0; i < 8; i++) send_byte(i);
        wait_state(3'd3, 20, "tx_compute");
        force_busy = 1'b1;
        fire_done(8);
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("send_hold_state", int'(o_state), 4);
            chk("send_hold_no_start", int'(o_ts), 0);
            chk("send_hold_rd", int'(o_rd), 0);
            cyc();
        end
        force_busy = 1'b0;
        wait_state(3'd0, 600, "tx_idle");
        chk("tx_count", ntx, 8);
        chk("tx_rq_left", rq.size(), 0);

        // abort after 3 bytes, then a fresh load from address 0
        do_reset(0);
        txlen = 2;
        for (int i = 0; i < 3; i++) send_byte(i);
        abort = 1'b1; cyc(); abort = 1'b0;
        smp();
        chk("abort_load_state", int'(o_state), 0);
        chk("abort_load_wa", int'(o_wa), 0);
        cyc();
        for (int i = 0; i < 8; i++) send_byte(i);
        wait_state(3'd3, 20, "reload_compute");
        fire_done(8);
        wait_state(3'd0, 400, "reload_idle");
        chk("reload_tx_count", ntx, 8);

        // timeout with TIMEOUT=10
        do_reset(1);
        for (int i = 0; i < 8; i++) send_byte(i);
        wait_state(3'd3, 20, "to_compute");
        n = 1;
        while (n < 50) begin
            cyc(); smp();
            if (o_state != 3'd3) break;
            n++;
        end
        chk("to_cycles", n, 10);
        chk("to_state", int'(o_state), 6);
        chk("to_err", int'(o_er), 1);
        chk("to_busy", int'(o_bz), 0);
        chk("to_no_tx", ntx, 0);
        cyc();
        abort = 1'b1; cyc(); abort = 1'b0;
        smp();
        chk("to_abort_state", int'(o_state), 0);
        chk("to_abort_err", int'(o_er), 0);
        cyc();
        for (int i = 0; i < 8; i++) send_byte(i);
        wait_state(3'd3, 20, "to2_compute");
        repeat (9) cyc();
        mult_done = 1'b1;
        for (int k = 0; k < 8; k++) rq.push_back(k);
        smp();
        chk("to2_tenth_cycle", int'(o_state), 3);
        cyc(); mult_done = 1'b0;
        smp();
        chk("to2_send", int'(o_state), 4);
        chk("to2_err", int'(o_er), 0);
        wait_state(3'd0, 400, "to2_idle");
        chk("to2_tx_count", ntx, 8);

        // async reset between edges during TX_WAIT
        do_reset(0);
        txlen = 5;
        for (int i = 0; i < 8; i++) send_byte(i);
        wait_state(3'd3, 20, "ar_compute");
        fire_done(8);
        wait_state(3'd5, 20, "ar_tx_wait");
        #2 rst = 1'b1;
        #1;
        chk("ar_outputs", outv(), 0);
        chk("ar_rd_addr", int'(o_rd), 0);
        @(posedge clk); #1 rst = 1'b0;
        rq.delete();
        txlen = 2;

        // DIM=1: two operand bytes, two result bytes
        do_reset(2);
        send_byte(0);
        send_byte(1);
        wait_state(3'd3, 20, "d1_compute");
        fire_done(2);
        wait_state(3'd0, 200, "d1_idle");
        chk("d1_tx_count", ntx, 2);
        chk("d1_ms_count", nms, 1);
        chk("d1_busy", int'(o_bz), 0);
        chk("d1_wq_left", wq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
